fsm_moore_seq: RTL and testbench
================================

FSM_MOORE_SEQ -- requirements
Module: fsm_moore_seq

Interface
REQ-001 The block SHALL have a parameter DW, default 2, giving the input symbol width in bits.
REQ-002 The block SHALL have a parameter DEPTH, default 4, giving the maximum pattern length in symbols (DEPTH >= 2).
REQ-003 The block SHALL have a parameter CNT_W, default 8, giving the match counter width.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 i_valid  input  1  when high, i_input is consumed this cycle.
REQ-008 i_input  input  DW  input symbol.
REQ-009 i_pat  input  DEPTH*DW  pattern; symbol k = i_pat[k*DW +: DW], with k=0 matched first.
REQ-010 i_len  input  $clog2(DEPTH+1)  active pattern length.
REQ-011 i_overlap  input  1  overlap mode enable.
REQ-012 i_clear  input  1  synchronous clear of the match counter.
REQ-013 o_output  output  1  Moore match flag.
REQ-014 o_prog  output  $clog2(DEPTH+1)  current progress (number of pattern symbols matched).
REQ-015 o_match_cnt  output  CNT_W  saturating match count.
REQ-016 o_cnt_sat  output  1  high while o_match_cnt equals all-ones.

Function
REQ-017 Effective length L SHALL be i_len clamped to the range 1..DEPTH (0 gives 1; values above DEPTH give DEPTH).
REQ-018 The states SHALL be IDLE (prog 0), PROG_k (prog k, 1 <= k < L) and MATCH; all are registered.
REQ-019 o_output SHALL depend only on the state: 1 in MATCH, 0 otherwise (Moore, no combinational path from inputs).
REQ-020 If i_valid=0, the state SHALL hold, except that MATCH SHALL also hold and o_output stays high until the next valid symbol.
REQ-021 With i_valid=1 at prog p and i_input==pat[p]: if p+1==L, next state SHALL be MATCH; otherwise prog SHALL become p+1.
REQ-022 With i_valid=1 and i_input!=pat[p]: next prog SHALL be 1 if i_input==pat[0], else 0 (simple restart; no full prefix search).
REQ-023 On entering MATCH, the retained progress r SHALL be 1 if i_overlap=1, L>1 and the completing symbol equals pat[0]; otherwise r SHALL be 0.
REQ-024 In MATCH, o_prog SHALL show r, and the next valid symbol SHALL be evaluated per REQ-021/022 with p=r.
REQ-025 With L=1, every valid symbol equal to pat[0] SHALL enter or remain in MATCH; a mismatch SHALL go to IDLE.
REQ-026 Latency SHALL be one cycle: o_output rises on the clock edge that samples the final matching symbol.
REQ-027 o_match_cnt SHALL increment by 1 on each transition into MATCH, including MATCH->MATCH, and SHALL saturate at 2^CNT_W-1.
REQ-028 i_clear SHALL zero the counter; if a match occurs in the same cycle, the result SHALL be 1.
REQ-029 i_pat, i_len and i_overlap SHALL be used live; a change mid-sequence SHALL take effect on the next valid symbol, with no additional reset of progress.

Reset
REQ-030 When rst=1 at a clock edge, the next state SHALL be IDLE, o_output=0, o_prog=0, o_match_cnt=0 and o_cnt_sat=0, regardless of i_valid and i_clear.
REQ-031 A reset asserted mid-sequence or during MATCH SHALL discard all progress; matching SHALL restart from pat[0] on the first valid symbol after rst deasserts.

Configuration
REQ-032 Macro FSM_MATCH_CNT_EN defined: the counter and the saturation logic SHALL be built as specified.
REQ-033 Macro FSM_MATCH_CNT_EN undefined: no counter flops SHALL exist, o_match_cnt and o_cnt_sat SHALL be tied to 0, and i_clear SHALL be ignored.

Verification
REQ-034 DW=2, DEPTH=4, pattern 00,11,00,10, L=4, i_overlap=0; stream 00,11,00,10 -> o_output=1 one cycle after the final 10 is sampled; o_match_cnt=1.
REQ-035 Same pattern; stream 00,11,01,00,11,00,10 -> the mismatch at 01 returns prog to 0; exactly one match, after the last symbol.
REQ-036 Pattern 00,11,00,00, L=4, i_overlap=1; stream 00,11,00,00,11,00,00 -> two matches (r=1 retained); with i_overlap=0 the same stream -> one match.
REQ-037 Match reached, then i_valid=0 for 3 cycles -> o_output stays 1 and the count is unchanged; asserting rst at prog=3 -> prog=0, o_output=0, o_match_cnt=0 on the next edge.
REQ-038 CNT_W=2, L=1, pattern 01; stream of 5 valid 01 symbols -> count 1,2,3,3,3 with o_cnt_sat=1 from the third match; i_clear with a simultaneous match -> count 1.
REQ-039 i_len=0 -> behaves as L=1; i_len=7 -> behaves as L=4; FSM_MATCH_CNT_EN undefined -> o_match_cnt=0 throughout REQ-034.

Source files
------------

// File: rtl/fsm_moore_seq.sv
// fsm_moore_seq: Moore sequence detector with live pattern, overlap mode and optional match counter (FSM_MATCH_CNT_EN)
module fsm_moore_seq #(
   parameter int DW    = 2,
   parameter int DEPTH = 4,
   parameter int CNT_W = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_valid,
   input  logic [DW-1:0]              i_input,
   input  logic [DEPTH*DW-1:0]        i_pat,
   input  logic [$clog2(DEPTH+1)-1:0] i_len,
   input  logic                       i_overlap,
   input  logic                       i_clear,
   output logic                       o_output,
   output logic [$clog2(DEPTH+1)-1:0] o_prog,
   output logic [CNT_W-1:0]           o_match_cnt,
   output logic                       o_cnt_sat
);
   localparam int PW = $clog2(DEPTH+1);
   logic          in_match, nxt_match, hit, first, done;
   logic [PW-1:0] prog, nxt_prog, len_eff;
   logic [DW-1:0] cur_sym;
   // state register: MATCH flag plus progress (retained r while in MATCH)
   always_ff @(posedge clk) begin
      if (rst) begin
         in_match <= 1'b0;
         prog     <= '0;
      end else begin
         in_match <= nxt_match;
         prog     <= nxt_prog;
      end
   end
   // next state: advance on hit, restart on pat[0] after a miss, L=1 re-enters MATCH on every pat[0]
   always_comb begin
      len_eff   = (i_len == '0) ? PW'(1) : (i_len > PW'(DEPTH)) ? PW'(DEPTH) : i_len;
      cur_sym   = i_pat[int'(prog)*DW +: DW];
      hit       = i_input == cur_sym;
      first     = i_input == i_pat[DW-1:0];
      done      = hit ? (prog + PW'(1) >= len_eff) : (first && len_eff == PW'(1));
      nxt_match = i_valid ? done : in_match;
      nxt_prog  = !i_valid ? prog :
                  done     ? PW'(i_overlap && len_eff > PW'(1) && first) :
                  hit      ? prog + PW'(1) : PW'(first);
   end
   // Moore outputs straight from the state
   always_comb begin
      o_output = in_match;
      o_prog   = prog;
   end
`ifdef FSM_MATCH_CNT_EN
   logic [CNT_W-1:0] cnt;
   logic             inc;
   assign inc = i_valid && nxt_match;
   // saturating match counter; clear wins over the old value but not over a same-cycle match
   always_ff @(posedge clk) begin
      if (rst)
         cnt <= '0;
      else if (i_clear)
         cnt <= inc ? CNT_W'(1) : '0;
      else if (inc && !(&cnt))
         cnt <= cnt + CNT_W'(1);
   end
   assign o_match_cnt = cnt;
   assign o_cnt_sat   = &cnt;
`else
   logic unused_clear;
   assign unused_clear = i_clear;
   assign o_match_cnt  = '0;
   assign o_cnt_sat    = 1'b0;
`endif
endmodule

// File: tb/tb_fsm_moore_seq.sv
// tb_fsm_moore_seq: directed-vector bench for fsm_moore_seq (CNT_W=8 and CNT_W=2 instances)
module tb_fsm_moore_seq;
   logic       clk = 0, rst = 1, valid = 0, ov = 0, clr = 0;
   logic [1:0] inp = 0;
   logic [7:0] pat = 0;
   logic [2:0] len = 3'd4;
   logic       out, out2, sat, sat2;
   logic [2:0] prog, prog2;
   logic [7:0] cnt;
   logic [1:0] cnt2;
   int         checks = 0, errors = 0;
`ifdef FSM_MATCH_CNT_EN
   localparam int CE = 1;
`else
   localparam int CE = 0;
`endif
   fsm_moore_seq #(.DW(2), .DEPTH(4), .CNT_W(8)) u_dut (
      .clk(clk), .rst(rst), .i_valid(valid), .i_input(inp), .i_pat(pat), .i_len(len),
      .i_overlap(ov), .i_clear(clr), .o_output(out), .o_prog(prog), .o_match_cnt(cnt), .o_cnt_sat(sat));
   fsm_moore_seq #(.DW(2), .DEPTH(4), .CNT_W(2)) u_dut2 (
      .clk(clk), .rst(rst), .i_valid(valid), .i_input(inp), .i_pat(pat), .i_len(len),
      .i_overlap(ov), .i_clear(clr), .o_output(out2), .o_prog(prog2), .o_match_cnt(cnt2), .o_cnt_sat(sat2));
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask
   task automatic step(input logic v, input logic [1:0] s);
      valid = v;
      inp   = s;
      @(posedge clk);
      #1;
   endtask
   task automatic do_reset();
      rst   = 1;
      valid = 1;
      clr   = 1;
      inp   = 2'b00;
      @(posedge clk);
      #1;
      rst   = 0;
      valid = 0;
      clr   = 0;
   endtask
   initial begin
      #1;
      pat = 8'b10_00_11_00;
      len = 3'd4;
      do_reset();
      check("rst_out", out, 0);
      check("rst_prog", prog, 0);
      check("rst_cnt", cnt, 0);
      check("rst_sat", sat, 0);
      step(1, 2'b00); check("a_prog1", prog, 1);
      step(1, 2'b11); check("a_prog2", prog, 2);
      step(1, 2'b00); check("a_prog3", prog, 3); check("a_out_pre", out, 0);
      step(1, 2'b10); check("a_out", out, 1); check("a_prog_r", prog, 0); check("a_cnt", cnt, CE * 1);
      for (int i = 0; i < 3; i++) step(0, 2'b11);
      check("hold_out", out, 1);
      check("hold_cnt", cnt, CE * 1);
      step(1, 2'b00); check("m_exit_out", out, 0); check("m_exit_prog", prog, 1);
      step(1, 2'b11);
      step(1, 2'b00); check("pre_rst_prog", prog, 3);
      rst = 1; step(1, 2'b10); rst = 0;
      check("mid_rst_prog", prog, 0); check("mid_rst_out", out, 0); check("mid_rst_cnt", cnt, 0);
      step(1, 2'b00); check("post_rst_prog", prog, 1);
      do_reset();
      step(1, 2'b00); step(1, 2'b11);
      step(1, 2'b01); check("b_miss_prog", prog, 0);
      step(1, 2'b00); step(1, 2'b11); step(1, 2'b00);
      check("b_out_pre", out, 0);
      step(1, 2'b10); check("b_out", out, 1); check("b_cnt", cnt, CE * 1);
      pat = 8'b00_00_11_00;
      ov  = 1;
      do_reset();
      step(1, 2'b00); step(1, 2'b11); step(1, 2'b00);
      step(1, 2'b00); check("c_out1", out, 1); check("c_r", prog, 1);
      step(1, 2'b11); check("c_prog2", prog, 2);
      step(1, 2'b00);
      step(1, 2'b00); check("c_out2", out, 1); check("c_cnt2", cnt, CE * 2);
      ov = 0;
      do_reset();
      step(1, 2'b00); step(1, 2'b11); step(1, 2'b00);
      step(1, 2'b00); check("d_out1", out, 1); check("d_r", prog, 0);
      step(1, 2'b11); check("d_restart", prog, 0);
      step(1, 2'b00);
      step(1, 2'b00); check("d_out_end", out, 0); check("d_prog_end", prog, 1); check("d_cnt", cnt, CE * 1);
      pat = 8'b00_00_00_01;
      len = 3'd1;
      do_reset();
      for (int i = 1; i <= 5; i++) begin
         step(1, 2'b01);
         check("e_out", out2, 1);
         check("e_cnt", cnt2, CE * ((i > 3) ? 3 : i));
         check("e_sat", sat2, CE * ((i >= 3) ? 1 : 0));
      end
      clr = 1; step(1, 2'b01); clr = 0;
      check("e_clr_match", cnt2, CE * 1); check("e_clr_sat", sat2, 0);
      clr = 1; step(0, 2'b01); clr = 0;
      check("e_clr_idle", cnt2, 0);
      step(1, 2'b10); check("e_miss_out", out2, 0); check("e_miss_prog", prog2, 0);
      len = 3'd0;
      do_reset();
      step(1, 2'b01); check("f_len0_out", out, 1);
      step(1, 2'b00); check("f_len0_miss", out, 0);
      pat = 8'b10_00_11_00;
      len = 3'd7;
      do_reset();
      step(1, 2'b00); step(1, 2'b11); step(1, 2'b00);
      check("g_len7_prog", prog, 3); check("g_len7_pre", out, 0);
      step(1, 2'b10); check("g_len7_out", out, 1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
